// File: rtl/modexp_operand_loader_if.sv
// ============================================================================
// modexp_operand_loader_if
// Operand stream, modexp control and key result bundle for the operand loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface modexp_operand_loader_if #(
    parameter int WIDTH = 4096,
    parameter int WORD  = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WORD-1:0]  in_data;
    logic             in_last;
    logic [WIDTH-1:0] key_i;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] mod;
    logic             start;
    logic             stall;
    logic             done;
    logic             valid;
    logic [WIDTH-1:0] modexp_out;
    logic [127:0]     key_o;
    logic             key_valid;
    logic             key_ready;
    logic             busy;
    logic             err;

    // Loader side
    modport master (
        input  in_valid, in_data, in_last, done, valid, modexp_out, key_ready,
        output in_ready, key_i, exp, mod, start, stall, key_o, key_valid, busy, err
    );

    // Host / modexp / consumer side
    modport slave (
        output in_valid, in_data, in_last, done, valid, modexp_out, key_ready,
        input  in_ready, key_i, exp, mod, start, stall, key_o, key_valid, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/modexp_operand_loader.sv
// ============================================================================
// modexp_operand_loader
// Assembles key/exponent/modulus from a word stream, runs modexp, returns key.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module modexp_operand_loader #(
    parameter int WIDTH = 4096,
    parameter int WORD  = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    modexp_operand_loader_if.master   bus
);
    localparam int NW = WIDTH / WORD;
    localparam int CW = $clog2(NW);
    localparam logic [CW-1:0] c_LAST_IDX = CW'(NW - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_KEY = 2'd0,
        SEL_EXP = 2'd1,
        SEL_MOD = 2'd2
    } sel_t;

    state_t                    r_state, w_state_n;
    sel_t                      r_sel, w_sel_n;
    logic [CW-1:0]             r_wcnt, w_wcnt_n;
    logic [NW-1:0][WORD-1:0]   r_key, r_exp, r_mod;
    logic [127:0]              r_key_o;
    logic                      r_start, r_stall, r_key_valid, r_err, r_busy;
    logic                      w_start_n, w_stall_n, w_key_valid_n, w_err_n, w_busy_n;
    logic                      w_xfer, w_last_word, w_clr, w_cap;
    logic                      w_unused_bits;

    assign w_xfer      = bus.in_valid && (r_state == ST_LOAD);
    assign w_last_word = bus.in_last || (r_wcnt == c_LAST_IDX);
    assign w_unused_bits = ^bus.modexp_out[WIDTH-1:128];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_sel       <= SEL_KEY;
            r_wcnt      <= '0;
            r_start     <= 1'b0;
            r_stall     <= 1'b0;
            r_key_valid <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_sel       <= w_sel_n;
            r_wcnt      <= w_wcnt_n;
            r_start     <= w_start_n;
            r_stall     <= w_stall_n;
            r_key_valid <= w_key_valid_n;
            r_err       <= w_err_n;
            r_busy      <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_sel_n       = r_sel;
        w_wcnt_n      = r_wcnt;
        w_start_n     = 1'b0;
        w_stall_n     = 1'b0;
        w_key_valid_n = 1'b0;
        w_err_n       = 1'b0;
        w_clr         = 1'b0;
        w_cap         = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (w_xfer) begin
                    if (w_last_word) begin
                        w_wcnt_n = '0;
                        if (r_sel == SEL_MOD) begin
                            w_sel_n   = SEL_KEY;
                            w_state_n = ST_START;
                        end else begin
                            w_sel_n = sel_t'(r_sel + 2'd1);
                        end
                    end else begin
                        w_wcnt_n = r_wcnt + 1'b1;
                    end
                end
            end
            ST_START: begin
                w_start_n = 1'b1;
                w_state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.done) begin
                    if (bus.valid) begin
                        w_cap     = 1'b1;
                        w_state_n = ST_HOLD;
                    end else begin
                        w_err_n   = 1'b1;
                        w_clr     = 1'b1;
                        w_state_n = ST_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                // key_valid/stall rise one cycle after entry; ready only counts once valid is up
                if (r_key_valid && bus.key_ready) begin
                    w_clr     = 1'b1;
                    w_state_n = ST_LOAD;
                end else begin
                    w_key_valid_n = 1'b1;
                    w_stall_n     = 1'b1;
                end
            end
            default: w_state_n = ST_LOAD;
        endcase
        w_busy_n = (w_state_n != ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
            r_exp <= '0;
            r_mod <= '0;
        end else if (w_clr) begin
            r_key <= '0;
            r_exp <= '0;
            r_mod <= '0;
        end else if (w_xfer) begin
            case (r_sel)
                SEL_KEY: r_key[r_wcnt] <= bus.in_data;
                SEL_EXP: r_exp[r_wcnt] <= bus.in_data;
                SEL_MOD: r_mod[r_wcnt] <= bus.in_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_o <= '0;
        end else if (w_cap) begin
            r_key_o <= bus.modexp_out[127:0];
        end
    end

    assign bus.in_ready  = (r_state == ST_LOAD);
    assign bus.key_i     = r_key;
    assign bus.exp       = r_exp;
    assign bus.mod       = r_mod;
    assign bus.start     = r_start;
    assign bus.stall     = r_stall;
    assign bus.key_o     = r_key_o;
    assign bus.key_valid = r_key_valid;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_modexp_operand_loader.sv
// ============================================================================
// tb_modexp_operand_loader
// Directed self-checking bench for the modexp operand loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modexp_operand_loader;
    localparam int WIDTH = 4096;
    localparam int WORD  = 32;
    localparam logic [127:0] c_KEY = 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_0001;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    modexp_operand_loader_if #(.WIDTH(WIDTH), .WORD(WORD)) bus ();

    modexp_operand_loader #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WORD-1:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Three single-word operands of value 1; returns with the loader in WAIT
    task automatic load_ones();
        send(32'h1, 1'b1);
        send(32'h1, 1'b1);
        send(32'h1, 1'b1);
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.done       = 1'b0;
        bus.valid      = 1'b0;
        bus.modexp_out = '0;
        bus.key_ready  = 1'b0;
        tick();
        tick();

        chk("rst_start", 128'(bus.start), 128'd0);
        chk("rst_stall", 128'(bus.stall), 128'd0);
        chk("rst_key_valid", 128'(bus.key_valid), 128'd0);
        chk("rst_err", 128'(bus.err), 128'd0);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_key_o", bus.key_o, 128'd0);
        chk("rst_key_i_zero", 128'(|bus.key_i), 128'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);

        // Single-word operands with in_last
        send(32'h1, 1'b1);
        send(32'h1, 1'b1);
        send(32'h1, 1'b1);
        chk("t2_start_latency", 128'(bus.start), 128'd0);
        chk("t2_busy", 128'(bus.busy), 128'd1);
        chk("t2_in_ready_low", 128'(bus.in_ready), 128'd0);
        tick();
        chk("t2_start_high", 128'(bus.start), 128'd1);
        chk("t2_key_i_lo", bus.key_i[127:0], 128'd1);
        chk("t2_exp_lo", bus.exp[127:0], 128'd1);
        chk("t2_mod_lo", bus.mod[127:0], 128'd1);
        chk("t2_upper_zero", 128'(|{bus.key_i[WIDTH-1:32], bus.exp[WIDTH-1:32], bus.mod[WIDTH-1:32]}), 128'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hFFFF_FFFF;
        tick();
        bus.in_valid = 1'b0;
        chk("t2_start_one_cycle", 128'(bus.start), 128'd0);
        chk("t2_ignore_in_wait", bus.key_i[127:0], 128'd1);

        // Valid without done is ignored
        bus.valid = 1'b1;
        tick();
        tick();
        chk("t3_valid_no_done", 128'(bus.key_valid), 128'd0);
        chk("t3_busy_wait", 128'(bus.busy), 128'd1);

        // Successful result with delayed consumer
        bus.done       = 1'b1;
        bus.modexp_out = {{(WIDTH-128){1'b1}}, c_KEY};
        tick();
        bus.done  = 1'b0;
        bus.valid = 1'b0;
        chk("t3_kv_latency", 128'(bus.key_valid), 128'd0);
        tick();
        chk("t3_key_o", bus.key_o, c_KEY);
        chk("t3_key_valid", 128'(bus.key_valid), 128'd1);
        chk("t3_stall", 128'(bus.stall), 128'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("t3_kv_held", 128'(bus.key_valid), 128'd1);
        chk("t3_stall_held", 128'(bus.stall), 128'd1);
        bus.key_ready = 1'b1;
        tick();
        bus.key_ready = 1'b0;
        chk("t3_kv_drop", 128'(bus.key_valid), 128'd0);
        chk("t3_stall_drop", 128'(bus.stall), 128'd0);
        chk("t3_in_ready", 128'(bus.in_ready), 128'd1);
        chk("t3_ops_cleared", 128'(|{bus.key_i, bus.exp, bus.mod}), 128'd0);
        chk("t3_busy_low", 128'(bus.busy), 128'd0);

        // done without valid -> error pulse
        load_ones();
        bus.done  = 1'b1;
        bus.valid = 1'b0;
        tick();
        bus.done = 1'b0;
        chk("t5_err_pulse", 128'(bus.err), 128'd1);
        chk("t5_in_ready", 128'(bus.in_ready), 128'd1);
        chk("t5_ops_zero", 128'(|{bus.key_i, bus.exp, bus.mod}), 128'd0);
        tick();
        chk("t5_err_one_cycle", 128'(bus.err), 128'd0);
        chk("t5_key_valid", 128'(bus.key_valid), 128'd0);

        // Full-length operands, in_last never asserted
        for (int i = 0; i < 384; i++) begin
            if (i == 383) chk("t4_busy_before_last", 128'(bus.busy), 128'd0);
            send(32'(i), 1'b0);
        end
        chk("t4_key_w0", 128'(bus.key_i[31:0]), 128'd0);
        chk("t4_key_w127", 128'(bus.key_i[127*32 +: 32]), 128'd127);
        chk("t4_exp_w0", 128'(bus.exp[31:0]), 128'd128);
        chk("t4_exp_w127", 128'(bus.exp[127*32 +: 32]), 128'd255);
        chk("t4_mod_w5", 128'(bus.mod[5*32 +: 32]), 128'd261);
        chk("t4_mod_w127", 128'(bus.mod[127*32 +: 32]), 128'd383);
        chk("t4_start_latency", 128'(bus.start), 128'd0);
        tick();
        chk("t4_start", 128'(bus.start), 128'd1);

        // Consumer always ready
        bus.key_ready  = 1'b1;
        bus.done       = 1'b1;
        bus.valid      = 1'b1;
        bus.modexp_out = {{(WIDTH-128){1'b0}}, 128'h1234};
        tick();
        bus.done  = 1'b0;
        bus.valid = 1'b0;
        chk("t6_kv_pre", 128'(bus.key_valid), 128'd0);
        chk("t6_in_ready_hold", 128'(bus.in_ready), 128'd0);
        tick();
        chk("t6_kv_high", 128'(bus.key_valid), 128'd1);
        chk("t6_key_o", bus.key_o, 128'h1234);
        tick();
        chk("t6_kv_one_cycle", 128'(bus.key_valid), 128'd0);
        chk("t6_in_ready", 128'(bus.in_ready), 128'd1);
        bus.key_ready = 1'b0;
        send(32'hA5A5_0001, 1'b0);
        chk("t6_next_load", 128'(bus.key_i[31:0]), 128'hA5A5_0001);
        send(32'hA5A5_0002, 1'b1);
        chk("t6_second_word", 128'(bus.key_i[63:32]), 128'hA5A5_0002);
        send(32'h7, 1'b1);
        chk("t6_sel_exp", 128'(bus.exp[31:0]), 128'h7);
        send(32'h9, 1'b1);
        tick();
        tick();

        // Asynchronous reset while waiting
        chk("t1_in_wait", 128'(bus.busy), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_start", 128'(bus.start), 128'd0);
        chk("t1_stall", 128'(bus.stall), 128'd0);
        chk("t1_busy", 128'(bus.busy), 128'd0);
        chk("t1_key_valid", 128'(bus.key_valid), 128'd0);
        chk("t1_ops_zero", 128'(|{bus.key_i, bus.exp, bus.mod}), 128'd0);
        chk("t1_key_o", bus.key_o, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t1_in_ready", 128'(bus.in_ready), 128'd1);
        chk("t1_kv_after", 128'(bus.key_valid), 128'd0);
        send(32'h3, 1'b1);
        chk("t1_load_after", 128'(bus.key_i[31:0]), 128'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
